debug_access_ctrl: RTL and testbench

DEBUG_ACCESS_CTRL -- requirements
Module: debug_access_ctrl

---
 rtl/debug_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_debug_access_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_access_ctrl.sv
// Debug access controller: single-steps or free-runs the CPU clock and performs
// debug register/memory reads and writes on behalf of a host command port.
module debug_access_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             clk_cpu,
  output logic             debug,
  output logic [31:0]      addr,
  output logic [31:0]      din,
  output logic             we_dm,
  output logic             we_im,
  output logic             clk_ld,
  input  logic [31:0]      dout_rf,
  input  logic [31:0]      dout_dm,
  input  logic [31:0]      dout_im,
  input  logic [31:0]      pc_chk
);

  localparam logic [2:0] OP_STEP  = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_HALT  = 3'd2;
  localparam logic [2:0] OP_RD_RF = 3'd3;
  localparam logic [2:0] OP_RD_DM = 3'd4;
  localparam logic [2:0] OP_RD_IM = 3'd5;
  localparam logic [2:0] OP_WR_DM = 3'd6;
  localparam logic [2:0] OP_WR_IM = 3'd7;

  typedef enum logic [3:0] {
    IDLE, PULSE_H, PULSE_L, SETTLE, RD_WAIT, RD_CAP, WR_SET, WR_CLK, RESP
  } state_t;

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [2:0]       op_sel;
  logic [CNT_W-1:0] count;
  logic [31:0]      bp;
  logic             running;
  logic             stop_req;
  logic             accept;
  logic             wr_next;

  // While running, the port stays open so any command can stop the run.
  always_comb begin
    cmd_ready = 1'b0;
    if (rstn) begin
      if (state == IDLE)
        cmd_ready = 1'b1;
      else if (running && (state == PULSE_H || state == PULSE_L))
        cmd_ready = 1'b1;
    end
  end

  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);
  assign op_sel    = (state == IDLE) ? cmd_op : op_q;
  assign wr_next   = (state_next == WR_SET) || (state_next == WR_CLK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_STEP, OP_RUN:            state_next = PULSE_H;
            OP_HALT:                    state_next = RESP;
            OP_RD_RF, OP_RD_DM, OP_RD_IM: state_next = RD_WAIT;
            default:                    state_next = WR_SET;
          endcase
        end
      end
      PULSE_H: state_next = PULSE_L;
      PULSE_L: begin
        if (running) begin
          if (stop_req || accept || pc_chk == bp) state_next = SETTLE;
          else                                    state_next = PULSE_H;
        end else if (count == '0) begin
          state_next = SETTLE;
        end else begin
          state_next = PULSE_H;
        end
      end
      SETTLE:  state_next = RESP;
      RD_WAIT: state_next = RD_CAP;
      RD_CAP:  state_next = RESP;
      WR_SET:  state_next = WR_CLK;
      WR_CLK:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CPU-facing strobes are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_cpu  <= 1'b0;
      debug    <= 1'b1;
      we_dm    <= 1'b0;
      we_im    <= 1'b0;
      clk_ld   <= 1'b0;
      addr     <= '0;
      din      <= '0;
      rsp_data <= '0;
      count    <= '0;
      bp       <= '0;
      op_q     <= OP_STEP;
      running  <= 1'b0;
      stop_req <= 1'b0;
    end else begin
      clk_cpu <= (state_next == PULSE_H);
      debug   <= !(state_next inside {PULSE_H, PULSE_L, SETTLE});
      we_dm   <= wr_next && (op_sel == OP_WR_DM);
      we_im   <= wr_next && (op_sel == OP_WR_IM);
      clk_ld  <= (state_next == WR_CLK);
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            addr     <= cmd_addr;
            din      <= cmd_data;
            bp       <= cmd_addr;
            running  <= (cmd_op == OP_RUN);
            stop_req <= 1'b0;
            if (cmd_op == OP_STEP)
              count <= (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
            else
              count <= '0;
            if (cmd_op == OP_HALT)
              rsp_data <= pc_chk;
          end
        end
        PULSE_H: begin
          if (!running && count != '0)
            count <= count - CNT_W'(1);
          // A stop seen during the high phase still lets the low phase finish.
          if (running && accept)
            stop_req <= 1'b1;
        end
        SETTLE: begin
          rsp_data <= pc_chk;
          running  <= 1'b0;
          stop_req <= 1'b0;
        end
        RD_CAP: begin
          case (op_q)
            OP_RD_RF: rsp_data <= dout_rf;
            OP_RD_DM: rsp_data <= dout_dm;
            default:  rsp_data <= dout_im;
          endcase
        end
        WR_CLK:  rsp_data <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Self-checking bench for debug_access_ctrl: directed vector table, corner-case
// sequences and random commands scored against a command-level CPU model.
module tb_debug_access_ctrl;

  localparam int CNT_W = 16;
  localparam logic [2:0] OP_STEP  = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_HALT  = 3'd2;
  localparam logic [2:0] OP_RD_RF = 3'd3;
  localparam logic [2:0] OP_RD_DM = 3'd4;
  localparam logic [2:0] OP_RD_IM = 3'd5;
  localparam logic [2:0] OP_WR_DM = 3'd6;
  localparam logic [2:0] OP_WR_IM = 3'd7;

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      exp_rsp;
    int               exp_lat;
    int               exp_pulses;
    int               hold;
  } vec_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             clk_cpu;
  logic             debug;
  logic [31:0]      addr;
  logic [31:0]      din;
  logic             we_dm;
  logic             we_im;
  logic             clk_ld;
  logic [31:0]      dout_rf;
  logic [31:0]      dout_dm;
  logic [31:0]      dout_im;
  logic [31:0]      pc_chk;
  logic             pc_clear;

  int n_checks = 0;
  int n_errors = 0;
  int ld_cnt   = 0;

  bit   [31:0] dm_mem   [64];
  bit   [31:0] im_mem   [64];
  logic [31:0] dm_model [64];
  logic [31:0] im_model [64];
  vec_t        tbl      [13];

  debug_access_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clk_cpu(clk_cpu), .debug(debug), .addr(addr), .din(din),
    .we_dm(we_dm), .we_im(we_im), .clk_ld(clk_ld),
    .dout_rf(dout_rf), .dout_dm(dout_dm), .dout_im(dout_im), .pc_chk(pc_chk)
  );

  always #5 clk = ~clk;

  // Emulated CPU: PC advances by 4 per CPU clock, memories load on clk_ld.
  always @(posedge clk_cpu or posedge pc_clear) begin
    if (pc_clear) pc_chk <= 32'd0;
    else          pc_chk <= pc_chk + 32'd4;
  end

  always @(posedge clk_ld) begin
    ld_cnt <= ld_cnt + 1;
    if (we_dm) dm_mem[addr[7:2]] <= din;
    if (we_im) im_mem[addr[7:2]] <= din;
  end

  always @(posedge clk) begin
    dout_rf <= 32'h1000_0000 | {26'd0, addr[7:2]};
    dout_dm <= dm_mem[addr[7:2]];
    dout_im <= im_mem[addr[7:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                               input logic [CNT_W-1:0] c, output logic [31:0] pc_start);
    int tries = 0;
    @(negedge clk);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_cnt   = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    pc_start = pc_chk;
    if (!cmd_ready) begin
      checkBit("cmd_accept", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(input int hold, output logic [31:0] data, output int lat,
                              output int wdm, output int wim, output int ldc,
                              output int ld_at, output int bad_dbg);
    bit done = 1'b0;
    data = '0; lat = 0; wdm = 0; wim = 0; ldc = 0; ld_at = 0; bad_dbg = 0;
    for (int i = 1; i <= 400 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1'b1;
        lat  = i;
      end else begin
        if (we_dm) wdm++;
        if (we_im) wim++;
        if (clk_ld) begin
          ldc++;
          if (ld_at == 0) ld_at = i;
        end
        if (clk_cpu && debug) bad_dbg++;
      end
    end
    if (!done) begin
      checkBit("rsp_timeout", rsp_valid, 1'b1);
      return;
    end
    data = rsp_data;
    checkBit("ready_in_resp", cmd_ready, 1'b0);
    checkBit("debug_in_resp", debug, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkBit("rsp_valid_hold", rsp_valid, 1'b1);
      checkOutput("rsp_data_hold", rsp_data, data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkBit("rsp_release", rsp_valid, 1'b0);
  endtask

  task automatic runVector(input string tag, input vec_t v);
    logic [31:0] pcs, got;
    int lat, wdm, wim, ldc, ldat, bdbg;
    bit is_wr;
    applyStimulus(v.op, v.addr, v.data, v.cnt, pcs);
    waitResponse(v.hold, got, lat, wdm, wim, ldc, ldat, bdbg);
    is_wr = (v.op == OP_WR_DM) || (v.op == OP_WR_IM);
    checkOutput({tag, "_rsp"}, got, v.exp_rsp);
    checkOutput({tag, "_latency"}, lat, v.exp_lat);
    checkOutput({tag, "_pulses"}, (pc_chk - pcs) >> 2, v.exp_pulses);
    checkOutput({tag, "_we_dm_cycles"}, wdm, (v.op == OP_WR_DM) ? 2 : 0);
    checkOutput({tag, "_we_im_cycles"}, wim, (v.op == OP_WR_IM) ? 2 : 0);
    checkOutput({tag, "_clk_ld_cycles"}, ldc, is_wr ? 1 : 0);
    checkOutput({tag, "_clk_ld_slot"}, ldat, is_wr ? 2 : 0);
    checkOutput({tag, "_debug_in_pulse"}, bdbg, 0);
  endtask

  // Command-level reference: pulses, latency and response from the op's rules.
  function automatic vec_t modelCommand(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] d, input logic [CNT_W-1:0] c,
                                        input logic [31:0] pc0, input int hold);
    vec_t v;
    int   np;
    v = '{op, a, d, c, 32'd0, 3, 0, hold};
    case (op)
      OP_STEP: begin
        np = (c == 0) ? 1 : int'(c);
        v.exp_rsp = pc0 + 32'(4 * np);
        v.exp_pulses = np;
        v.exp_lat = 2 * np + 2;
      end
      OP_RUN: begin
        np = int'((a - pc0) / 4);
        v.exp_rsp = a;
        v.exp_pulses = np;
        v.exp_lat = 2 * np + 2;
      end
      OP_HALT:  begin v.exp_rsp = pc0; v.exp_lat = 1; end
      OP_RD_RF: v.exp_rsp = 32'h1000_0000 + {26'd0, a[7:2]};
      OP_RD_DM: v.exp_rsp = dm_model[a[7:2]];
      OP_RD_IM: v.exp_rsp = im_model[a[7:2]];
      default:  v.exp_rsp = d;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] pcs, got, pc_stop, pc_hold;
    int lat, wdm, wim, ldc, ldat, bdbg, tries, ld_before;
    vec_t v;

    tbl[0]  = '{OP_STEP,  32'h0,  32'h0,         16'd3, 32'h0000_000C, 8,  3, 1};
    tbl[1]  = '{OP_STEP,  32'h0,  32'h0,         16'd0, 32'h0000_0004, 4,  1, 1};
    tbl[2]  = '{OP_STEP,  32'h0,  32'h0,         16'd1, 32'h0000_0004, 4,  1, 0};
    tbl[3]  = '{OP_STEP,  32'h0,  32'h0,         16'd5, 32'h0000_0014, 12, 5, 2};
    tbl[4]  = '{OP_HALT,  32'h0,  32'h0,         16'd0, 32'h0000_0000, 1,  0, 1};
    tbl[5]  = '{OP_WR_IM, 32'h4,  32'hDEAD_BEEF, 16'd0, 32'hDEAD_BEEF, 3,  0, 1};
    tbl[6]  = '{OP_RD_IM, 32'h4,  32'h0,         16'd0, 32'hDEAD_BEEF, 3,  0, 1};
    tbl[7]  = '{OP_WR_DM, 32'h10, 32'h1234_5678, 16'd0, 32'h1234_5678, 3,  0, 0};
    tbl[8]  = '{OP_RD_DM, 32'h10, 32'h0,         16'd0, 32'h1234_5678, 3,  0, 5};
    tbl[9]  = '{OP_RD_IM, 32'h10, 32'h0,         16'd0, 32'h0000_0000, 3,  0, 1};
    tbl[10] = '{OP_RD_RF, 32'h8,  32'h0,         16'd0, 32'h1000_0002, 3,  0, 1};
    tbl[11] = '{OP_RUN,   32'h20, 32'h0,         16'd0, 32'h0000_0020, 18, 8, 1};
    tbl[12] = '{OP_RUN,   32'h4,  32'h0,         16'd0, 32'h0000_0004, 4,  1, 1};

    for (int i = 0; i < 64; i++) begin
      dm_model[i] = '0;
      im_model[i] = '0;
    end
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_cnt = '0;
    rsp_ready = 1'b0;
    pc_clear  = 1'b0;
    rstn      = 1'b1;
    #1;
    rstn     = 1'b0;
    pc_clear = 1'b1;
    #1;
    pc_clear = 1'b0;

    repeat (3) @(negedge clk);
    checkBit("reset_clk_cpu", clk_cpu, 1'b0);
    checkBit("reset_debug", debug, 1'b1);
    checkBit("reset_we_dm", we_dm, 1'b0);
    checkBit("reset_we_im", we_im, 1'b0);
    checkBit("reset_clk_ld", clk_ld, 1'b0);
    checkOutput("reset_addr", addr, 32'd0);
    checkOutput("reset_din", din, 32'd0);
    checkBit("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkBit("reset_cmd_ready", cmd_ready, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    checkBit("post_reset_ready", cmd_ready, 1'b1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      pc_clear = 1'b1;
      #1;
      pc_clear = 1'b0;
      runVector($sformatf("vec%0d", i), tbl[i]);
      if (tbl[i].op == OP_WR_DM) dm_model[tbl[i].addr[7:2]] = tbl[i].data;
      if (tbl[i].op == OP_WR_IM) im_model[tbl[i].addr[7:2]] = tbl[i].data;
    end
    checkOutput("write_addr_seen", addr, 32'h0000_0004);

    $display("[TB] RUN with unreachable breakpoint, stopped by HALT");
    applyStimulus(OP_RUN, 32'h0000_0003, 32'h0, '0, pcs);
    tries = 0;
    while ((pc_chk - pcs) < 32'd40 && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    checkOutput("run_ten_pulses", pc_chk - pcs, 32'd40);
    checkBit("ready_while_running", cmd_ready, 1'b1);
    applyStimulus(OP_HALT, 32'h0, 32'h0, '0, pc_stop);
    waitResponse(1, got, lat, wdm, wim, ldc, ldat, bdbg);
    checkOutput("run_halt_rsp", got, pcs + 32'd40);
    checkOutput("run_halt_pc_frozen", pc_chk, pcs + 32'd40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("run_no_second_rsp", rsp_valid, 1'b0);
    end
    checkOutput("run_no_more_pulses", pc_chk, pcs + 32'd40);

    $display("[TB] reset during WR_SET");
    applyStimulus(OP_WR_IM, 32'h40, 32'hCAFE_F00D, '0, pcs);
    checkBit("wr_set_we_im", we_im, 1'b1);
    checkBit("wr_set_clk_ld", clk_ld, 1'b0);
    ld_before = ld_cnt;
    #2;
    rstn = 1'b0;
    #1;
    checkBit("wr_abort_we_im", we_im, 1'b0);
    checkBit("wr_abort_clk_ld", clk_ld, 1'b0);
    checkBit("wr_abort_debug", debug, 1'b1);
    checkBit("wr_abort_ready", cmd_ready, 1'b0);
    checkOutput("wr_abort_addr", addr, 32'd0);
    checkOutput("wr_abort_din", din, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("wr_abort_no_load", ld_cnt, ld_before);
    runVector("wr_abort_readback", modelCommand(OP_RD_IM, 32'h40, 32'h0, '0, pc_chk, 1));

    $display("[TB] reset during STEP pulses");
    applyStimulus(OP_STEP, 32'h0, 32'h0, 16'd6, pcs);
    repeat (3) @(negedge clk);
    checkBit("step_mid_clk_cpu_high", clk_cpu, 1'b1);
    rstn = 1'b0;
    #1;
    checkBit("step_abort_clk_cpu", clk_cpu, 1'b0);
    pc_hold = pc_chk;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("step_abort_no_edge", pc_chk, pc_hold);
    checkBit("step_abort_idle", cmd_ready, 1'b1);

    $display("[TB] random commands against reference model");
    for (int n = 0; n < 40; n++) begin
      logic [2:0]       op;
      logic [31:0]      a, d;
      logic [CNT_W-1:0] c;
      op = 3'($urandom_range(0, 7));
      a  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      d  = $urandom;
      c  = CNT_W'($urandom_range(0, 4));
      if (op == OP_RUN) a = pc_chk + 32'(4 * $urandom_range(1, 6));
      v = modelCommand(op, a, d, c, pc_chk, int'($urandom_range(0, 3)));
      runVector($sformatf("rnd%0d_op%0d", n, op), v);
      if (op == OP_WR_DM) dm_model[a[7:2]] = d;
      if (op == OP_WR_IM) im_model[a[7:2]] = d;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
